// File: rtl/bus_arbiter.sv
// bus_arbiter
// Shares one SRAM-style bus between the instruction-fetch port and the data
// port. One single-word transfer runs at a time. Each result is held in a
// per-port register until the owning pipeline stage advances, so that stage
// can pick it up late without issuing the access again.
//
// Ports
//   clk, rst           : clock; asynchronous active-high reset
//   stall_i[5:0]       : pipeline stall vector (bit1 = IF, bit4 = MEM)
//   flush_i            : pipeline flush
//   ibus_*_i / _o      : fetch request, address, instruction, stall request
//   dbus_*_i / _o      : data request, we, sel, address, store data,
//                        load data, stall request
//   bus_*_o / bus_*_i  : external bus strobe, we, sel, address, write data,
//                        read data, ack
//
// state | meaning
// IDLE  | no transfer; arbitrate between the pending ports
// DBUS  | data-port transfer on the bus, waiting for ack
// IBUS  | fetch transfer on the bus, waiting for ack
module bus_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        ibus_ce_i,
  input  logic [31:0] ibus_addr_i,
  output logic [31:0] ibus_data_o,
  output logic        ibus_stallreq_o,
  input  logic        dbus_ce_i,
  input  logic        dbus_we_i,
  input  logic [3:0]  dbus_sel_i,
  input  logic [31:0] dbus_addr_i,
  input  logic [31:0] dbus_data_i,
  output logic [31:0] dbus_data_o,
  output logic        dbus_stallreq_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {S_IDLE, S_DBUS, S_IBUS} state_t;

  state_t      state_q, state_d;
  logic        d_hold_q, d_hold_d;
  logic        i_hold_q, i_hold_d;
  logic        discard_q, discard_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic d_pend, i_pend;

  // Only the IF and MEM stall bits matter here.
  logic unused_stall;
  assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  assign d_pend = dbus_ce_i & ~d_hold_q & ~flush_i;
  assign i_pend = ibus_ce_i & ~i_hold_q & ~flush_i;

  always_comb begin
    state_d   = state_q;
    d_hold_d  = d_hold_q;
    i_hold_d  = i_hold_q;
    discard_d = discard_q;
    d_rdata_d = d_rdata_q;
    i_rdata_d = i_rdata_q;
    stb_d     = stb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    // A hold flag lives until its stage advances or the pipeline flushes.
    if (!stall_i[4] || flush_i) d_hold_d = 1'b0;
    if (!stall_i[1] || flush_i) i_hold_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (d_pend && (DATA_FIRST || !i_pend)) begin
          state_d = S_DBUS;
          stb_d   = 1'b1;
          we_d    = dbus_we_i;
          sel_d   = dbus_sel_i;
          addr_d  = dbus_addr_i;
          wdata_d = dbus_data_i;
        end else if (i_pend) begin
          state_d = S_IBUS;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = 4'b1111;
          addr_d  = ibus_addr_i;
          wdata_d = 32'h0;
        end
      end
      S_DBUS, S_IBUS: begin
        // A transfer is never aborted; a flush only marks its result as dead.
        if (flush_i) discard_d = 1'b1;
        if (bus_ack_i) begin
          state_d = S_IDLE;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'b0000;
          // Flush on the ack edge itself also kills the result.
          if (discard_q || flush_i) begin
            discard_d = 1'b0;
          end else if (state_q == S_DBUS) begin
            d_rdata_d = bus_data_i;
            d_hold_d  = 1'b1;
          end else begin
            i_rdata_d = bus_data_i;
            i_hold_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      d_hold_q  <= 1'b0;
      i_hold_q  <= 1'b0;
      discard_q <= 1'b0;
      d_rdata_q <= 32'h0;
      i_rdata_q <= 32'h0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'b0000;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      d_hold_q  <= d_hold_d;
      i_hold_q  <= i_hold_d;
      discard_q <= discard_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Gated by rst so both stall requests drop the moment reset asserts.
  assign dbus_stallreq_o = dbus_ce_i & ~d_hold_q & ~flush_i & ~rst;
  assign ibus_stallreq_o = ibus_ce_i & ~i_hold_q & ~flush_i & ~rst;

  assign dbus_data_o = d_rdata_q;
  assign ibus_data_o = i_rdata_q;
  assign bus_stb_o   = stb_q;
  assign bus_we_o    = we_q;
  assign bus_sel_o   = sel_q;
  assign bus_addr_o  = addr_q;
  assign bus_data_o  = wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        ibus_ce_i;
  logic [31:0] ibus_addr_i;
  logic [31:0] ibus_data_o;
  logic        ibus_stallreq_o;
  logic        dbus_ce_i;
  logic        dbus_we_i;
  logic [3:0]  dbus_sel_i;
  logic [31:0] dbus_addr_i;
  logic [31:0] dbus_data_i;
  logic [31:0] dbus_data_o;
  logic        dbus_stallreq_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;

  bus_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .ibus_ce_i(ibus_ce_i), .ibus_addr_i(ibus_addr_i), .ibus_data_o(ibus_data_o),
    .ibus_stallreq_o(ibus_stallreq_o),
    .dbus_ce_i(dbus_ce_i), .dbus_we_i(dbus_we_i), .dbus_sel_i(dbus_sel_i),
    .dbus_addr_i(dbus_addr_i), .dbus_data_i(dbus_data_i), .dbus_data_o(dbus_data_o),
    .dbus_stallreq_o(dbus_stallreq_o),
    .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
    .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] dres_q[$];
  logic [31:0] ires_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          wait_cfg = 0;

  bit t2_stb [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  bit t2_isr [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Slave: acks after wait_cfg wait cycles; read data 0xDEADBEEF at 0x100,
  // otherwise 0xC0DE0000 | addr.
  initial begin
    int wcnt;
    wcnt = 0;
    bus_ack_i = 1'b0;
    bus_data_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_stb_o && !rst) begin
        bus_data_i = (bus_addr_o == 32'h100) ? 32'hDEADBEEF : (32'hC0DE0000 | bus_addr_o);
        if (wcnt == wait_cfg) bus_ack_i = 1'b1;
        else begin
          bus_ack_i = 1'b0;
          wcnt++;
        end
      end else begin
        bus_ack_i = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Bus monitor: every completed transfer must match the next expected one.
  initial begin
    bus_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus_stb_o && bus_ack_i) begin
        if (bus_q.size() == 0) chk("bus unexpected transfer", bus_addr_o, 32'hFFFFFFFF);
        else begin
          e = bus_q.pop_front();
          chk("bus we", {31'h0, bus_we_o}, {31'h0, e.we});
          chk("bus sel", {28'h0, bus_sel_o}, {28'h0, e.sel});
          chk("bus addr", bus_addr_o, e.addr);
          chk("bus wdata", bus_data_o, e.data);
        end
      end
    end
  end

  // Result monitor: a stall request falling while the port still requests
  // means the result is being presented.
  initial begin
    logic d_prev, i_prev;
    logic [31:0] e;
    d_prev = 1'b0;
    i_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && !flush_i) begin
        if (d_prev && !dbus_stallreq_o && dbus_ce_i && !dbus_we_i) begin
          if (dres_q.size() == 0) chk("dbus unexpected result", dbus_data_o, 32'hFFFFFFFF);
          else begin
            e = dres_q.pop_front();
            chk("dbus result", dbus_data_o, e);
          end
        end
        if (i_prev && !ibus_stallreq_o && ibus_ce_i) begin
          if (ires_q.size() == 0) chk("ibus unexpected result", ibus_data_o, 32'hFFFFFFFF);
          else begin
            e = ires_q.pop_front();
            chk("ibus result", ibus_data_o, e);
          end
        end
      end
      d_prev = dbus_stallreq_o;
      i_prev = ibus_stallreq_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    stall_i = 6'b0;
    flush_i = 1'b0;
    ibus_ce_i = 1'b1;
    ibus_addr_i = 32'h0;
    dbus_ce_i = 1'b1;
    dbus_we_i = 1'b0;
    dbus_sel_i = 4'hF;
    dbus_addr_i = 32'h0;
    dbus_data_i = 32'h0;
    repeat (2) @(posedge clk);
    smp();
    chk("reset stb", {31'h0, bus_stb_o}, 32'h0);
    chk("reset dsr", {31'h0, dbus_stallreq_o}, 32'h0);
    chk("reset isr", {31'h0, ibus_stallreq_o}, 32'h0);
    chk("reset sel", {28'h0, bus_sel_o}, 32'h0);
    chk("reset addr", bus_addr_o, 32'h0);
    chk("reset ddata", dbus_data_o, 32'h0);
    chk("reset idata", ibus_data_o, 32'h0);
    cyc();
    ibus_ce_i = 1'b0;
    dbus_ce_i = 1'b0;
    cyc();
    rst = 1'b0;
    repeat (2) cyc();

    // Single load, zero-wait slave
    dbus_ce_i = 1'b1; dbus_we_i = 1'b0; dbus_sel_i = 4'hF;
    dbus_addr_i = 32'h100; dbus_data_i = 32'h0; wait_cfg = 0;
    bus_q.push_back('{1'b0, 4'hF, 32'h100, 32'h0});
    dres_q.push_back(32'hDEADBEEF);
    smp();
    chk("t1 c0 stb", {31'h0, bus_stb_o}, 32'h0);
    chk("t1 c0 dsr", {31'h0, dbus_stallreq_o}, 32'h1);
    cyc(); smp();
    chk("t1 c1 stb", {31'h0, bus_stb_o}, 32'h1);
    chk("t1 c1 dsr", {31'h0, dbus_stallreq_o}, 32'h1);
    cyc(); smp();
    chk("t1 c2 stb", {31'h0, bus_stb_o}, 32'h0);
    chk("t1 c2 dsr", {31'h0, dbus_stallreq_o}, 32'h0);
    chk("t1 c2 ddata", dbus_data_o, 32'hDEADBEEF);
    cyc();
    dbus_ce_i = 1'b0;
    smp();
    chk("t1 c3 stb", {31'h0, bus_stb_o}, 32'h0);
    repeat (2) cyc();

    // Conflict: data first, then fetch; slave waits 2 cycles
    dbus_ce_i = 1'b1; dbus_addr_i = 32'h200;
    ibus_ce_i = 1'b1; ibus_addr_i = 32'h300; wait_cfg = 2;
    bus_q.push_back('{1'b0, 4'hF, 32'h200, 32'h0});
    bus_q.push_back('{1'b0, 4'hF, 32'h300, 32'h0});
    dres_q.push_back(32'hC0DE0200);
    ires_q.push_back(32'hC0DE0300);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) cyc();
      if (c == 5) dbus_ce_i = 1'b0;
      smp();
      chk($sformatf("t2 c%0d stb", c), {31'h0, bus_stb_o}, {31'h0, t2_stb[c]});
      chk($sformatf("t2 c%0d isr", c), {31'h0, ibus_stallreq_o}, {31'h0, t2_isr[c]});
    end
    cyc();
    ibus_ce_i = 1'b0;
    repeat (2) cyc();

    // Store with sel 0011, one wait cycle
    dbus_ce_i = 1'b1; dbus_we_i = 1'b1; dbus_sel_i = 4'b0011;
    dbus_addr_i = 32'h40; dbus_data_i = 32'h0000ABCD; wait_cfg = 1;
    bus_q.push_back('{1'b1, 4'b0011, 32'h40, 32'h0000ABCD});
    smp();
    cyc(); smp();
    chk("t3 c1 stb", {31'h0, bus_stb_o}, 32'h1);
    chk("t3 c1 we", {31'h0, bus_we_o}, 32'h1);
    chk("t3 c1 sel", {28'h0, bus_sel_o}, 32'h3);
    chk("t3 c1 wdata", bus_data_o, 32'h0000ABCD);
    cyc(); smp();
    chk("t3 c2 dsr", {31'h0, dbus_stallreq_o}, 32'h1);
    cyc(); smp();
    chk("t3 c3 dsr", {31'h0, dbus_stallreq_o}, 32'h0);
    chk("t3 c3 we", {31'h0, bus_we_o}, 32'h0);
    chk("t3 c3 sel", {28'h0, bus_sel_o}, 32'h0);
    cyc();
    dbus_ce_i = 1'b0; dbus_we_i = 1'b0; dbus_sel_i = 4'hF; dbus_data_i = 32'h0;
    repeat (2) cyc();

    // Hold while MEM is stalled, then a new access after release
    stall_i = 6'b011111;
    dbus_ce_i = 1'b1; dbus_addr_i = 32'h500; wait_cfg = 0;
    bus_q.push_back('{1'b0, 4'hF, 32'h500, 32'h0});
    dres_q.push_back(32'hC0DE0500);
    smp();
    cyc(); smp();
    chk("t4 c1 stb", {31'h0, bus_stb_o}, 32'h1);
    for (int c = 2; c < 5; c++) begin
      cyc(); smp();
      chk($sformatf("t4 c%0d dsr", c), {31'h0, dbus_stallreq_o}, 32'h0);
      chk($sformatf("t4 c%0d ddata", c), dbus_data_o, 32'hC0DE0500);
    end
    cyc();
    stall_i = 6'b0;
    dbus_addr_i = 32'h600;
    bus_q.push_back('{1'b0, 4'hF, 32'h600, 32'h0});
    dres_q.push_back(32'hC0DE0600);
    smp();
    chk("t4 c5 dsr", {31'h0, dbus_stallreq_o}, 32'h0);
    cyc(); smp();
    chk("t4 c6 dsr", {31'h0, dbus_stallreq_o}, 32'h1);
    chk("t4 c6 stb", {31'h0, bus_stb_o}, 32'h0);
    cyc(); smp();
    chk("t4 c7 stb", {31'h0, bus_stb_o}, 32'h1);
    cyc(); smp();
    chk("t4 c8 dsr", {31'h0, dbus_stallreq_o}, 32'h0);
    chk("t4 c8 ddata", dbus_data_o, 32'hC0DE0600);
    cyc();
    dbus_ce_i = 1'b0;
    repeat (2) cyc();

    // Flush in the middle of a fetch
    ibus_ce_i = 1'b1; ibus_addr_i = 32'h700; wait_cfg = 2;
    bus_q.push_back('{1'b0, 4'hF, 32'h700, 32'h0});
    smp();
    cyc(); smp();
    chk("t5 c1 stb", {31'h0, bus_stb_o}, 32'h1);
    cyc();
    flush_i = 1'b1;
    smp();
    chk("t5 c2 isr", {31'h0, ibus_stallreq_o}, 32'h0);
    cyc();
    flush_i = 1'b0;
    smp();
    chk("t5 c3 stb", {31'h0, bus_stb_o}, 32'h1);
    cyc();
    ibus_addr_i = 32'h800;
    bus_q.push_back('{1'b0, 4'hF, 32'h800, 32'h0});
    ires_q.push_back(32'hC0DE0800);
    smp();
    chk("t5 c4 stb", {31'h0, bus_stb_o}, 32'h0);
    chk("t5 c4 isr", {31'h0, ibus_stallreq_o}, 32'h1);
    chk("t5 c4 idata", ibus_data_o, 32'hC0DE0300);
    cyc(); smp();
    chk("t5 c5 stb", {31'h0, bus_stb_o}, 32'h1);
    chk("t5 c5 addr", bus_addr_o, 32'h800);
    repeat (3) cyc();
    smp();
    chk("t5 c8 isr", {31'h0, ibus_stallreq_o}, 32'h0);
    chk("t5 c8 idata", ibus_data_o, 32'hC0DE0800);
    cyc();
    ibus_ce_i = 1'b0;
    repeat (2) cyc();

    // Reset in the middle of a data transfer
    dbus_ce_i = 1'b1; dbus_addr_i = 32'h900;
    ibus_ce_i = 1'b1; ibus_addr_i = 32'hA00; wait_cfg = 3;
    smp();
    cyc(); smp();
    chk("t6 c1 stb", {31'h0, bus_stb_o}, 32'h1);
    chk("t6 c1 addr", bus_addr_o, 32'h900);
    #2;
    rst = 1'b1;
    #1;
    chk("t6 rst stb", {31'h0, bus_stb_o}, 32'h0);
    chk("t6 rst dsr", {31'h0, dbus_stallreq_o}, 32'h0);
    chk("t6 rst isr", {31'h0, ibus_stallreq_o}, 32'h0);
    chk("t6 rst we", {31'h0, bus_we_o}, 32'h0);
    chk("t6 rst sel", {28'h0, bus_sel_o}, 32'h0);
    chk("t6 rst addr", bus_addr_o, 32'h0);
    chk("t6 rst wdata", bus_data_o, 32'h0);
    chk("t6 rst ddata", dbus_data_o, 32'h0);
    chk("t6 rst idata", ibus_data_o, 32'h0);
    cyc();
    dbus_ce_i = 1'b0;
    ibus_ce_i = 1'b0;
    cyc();
    rst = 1'b0;
    repeat (2) cyc();
    smp();
    chk("end stb", {31'h0, bus_stb_o}, 32'h0);
    chk("end bus queue", bus_q.size(), 32'h0);
    chk("end dres queue", dres_q.size(), 32'h0);
    chk("end ires queue", ires_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
